// File: rtl/tx_sched_pkg.sv
// Shared types for the TX scheduler: FSM state encoding and the byte type
// carried on both the command and data channels.
package tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        ISSUE = 2'd2,
        GAP   = 2'd3
    } tx_sched_state_e;

    typedef logic [7:0] tx_byte_t;

endpackage

// File: rtl/tx_sched_watchdog.sv
// Mid-frame watchdog: counts enabled cycles and flags the cycle that reaches
// FRAME_TIMEOUT. The count saturates and never wraps.
module tx_sched_watchdog #(
    parameter int FRAME_TIMEOUT = 255
) (
    input  logic CLK_I,
    input  logic RST_NI,
    input  logic CLEAR_I,
    input  logic ENABLE_I,
    output logic EXPIRE_O
);

    localparam int TW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [TW-1:0] TERMINAL  = TW'(FRAME_TIMEOUT - 1);
    localparam logic [TW-1:0] SATURATED = TW'(FRAME_TIMEOUT);

    logic [TW-1:0] count_reg;

    // Expiry fires on the enabled cycle that would take the count to FRAME_TIMEOUT.
    assign EXPIRE_O = ENABLE_I && !CLEAR_I && (count_reg == TERMINAL);

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            count_reg <= '0;
        end else if (CLEAR_I) begin
            count_reg <= '0;
        end else if (ENABLE_I && (count_reg != SATURATED)) begin
            count_reg <= count_reg + TW'(1);
        end
    end

endmodule

// File: rtl/tx_scheduler.sv
// Arbitrates the command and data channels onto the single escaping TX path.
// Data frames are atomic; commands win only at frame boundaries, bounded by a starvation limit.
module tx_scheduler
    import tx_sched_pkg::*;
#(
    parameter int CMD_MAX_CONSEC = 4,
    parameter int FRAME_TIMEOUT  = 255
) (
    input  logic       CLK_I,
    input  logic       RST_NI,
    input  logic       CMD_VALID_I,
    input  logic [7:0] CMD_I,
    output logic       CMD_READY_O,
    input  logic       DATA_VALID_I,
    input  logic [7:0] DATA_I,
    input  logic       DATA_LAST_I,
    output logic       DATA_READY_O,
    input  logic       TX_READY_I,
    output logic       WRITE_O,
    output logic       WRITE_COMMAND_O,
    output logic [7:0] DATA_SEND_O,
    output logic [7:0] COMMAND_O,
    output logic       BUSY_O,
    output logic       FRAME_ABORT_O
);

    localparam int CW = $clog2(CMD_MAX_CONSEC + 1);
    localparam logic [CW-1:0] CONSEC_MAX = CW'(CMD_MAX_CONSEC);

    tx_sched_state_e state_reg;
    logic [CW-1:0]   consec_reg;
    logic            frame_open_reg;
    logic            write_reg;
    logic            write_cmd_reg;
    logic            abort_reg;
    tx_byte_t        data_send_reg;
    tx_byte_t        command_reg;

    logic cmd_sel;
    logic cmd_ready;
    logic data_ready;
    logic cmd_acc;
    logic data_acc;
    logic wd_enable;
    logic wd_clear;
    logic wd_expire;

    // Readies are gated by RST_NI so they drop with the asynchronous reset too.
    always_comb begin
        cmd_sel    = CMD_VALID_I && !(DATA_VALID_I && (consec_reg == CONSEC_MAX));
        cmd_ready  = RST_NI && TX_READY_I && (state_reg == IDLE) && cmd_sel;
        data_ready = RST_NI && TX_READY_I &&
                     ((state_reg == FRAME) || ((state_reg == IDLE) && !cmd_sel));
        cmd_acc    = CMD_VALID_I && cmd_ready;
        data_acc   = DATA_VALID_I && data_ready;
        wd_enable  = (state_reg == FRAME) && TX_READY_I && !DATA_VALID_I;
        wd_clear   = (state_reg != FRAME) || data_acc;
    end

    tx_sched_watchdog #(
        .FRAME_TIMEOUT(FRAME_TIMEOUT)
    ) u_watchdog (
        .CLK_I   (CLK_I),
        .RST_NI  (RST_NI),
        .CLEAR_I (wd_clear),
        .ENABLE_I(wd_enable),
        .EXPIRE_O(wd_expire)
    );

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_reg      <= IDLE;
            consec_reg     <= '0;
            frame_open_reg <= 1'b0;
            write_reg      <= 1'b0;
            write_cmd_reg  <= 1'b0;
            abort_reg      <= 1'b0;
            data_send_reg  <= '0;
            command_reg    <= '0;
        end else begin
            write_reg     <= 1'b0;
            write_cmd_reg <= 1'b0;
            abort_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_acc) begin
                        command_reg    <= CMD_I;
                        write_cmd_reg  <= 1'b1;
                        frame_open_reg <= 1'b0;
                        state_reg      <= ISSUE;
                        // Only grants made over a waiting frame count toward starvation.
                        if (!DATA_VALID_I) begin
                            consec_reg <= '0;
                        end else if (consec_reg != CONSEC_MAX) begin
                            consec_reg <= consec_reg + CW'(1);
                        end
                    end else if (data_acc) begin
                        data_send_reg  <= DATA_I;
                        write_reg      <= 1'b1;
                        frame_open_reg <= !DATA_LAST_I;
                        consec_reg     <= '0;
                        state_reg      <= ISSUE;
                    end
                end
                FRAME: begin
                    if (data_acc) begin
                        data_send_reg  <= DATA_I;
                        write_reg      <= 1'b1;
                        frame_open_reg <= !DATA_LAST_I;
                        consec_reg     <= '0;
                        state_reg      <= ISSUE;
                    end else if (wd_expire) begin
                        abort_reg      <= 1'b1;
                        frame_open_reg <= 1'b0;
                        consec_reg     <= '0;
                        state_reg      <= IDLE;
                    end
                end
                ISSUE: begin
                    state_reg <= GAP;
                end
                GAP: begin
                    state_reg <= frame_open_reg ? FRAME : IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign CMD_READY_O     = cmd_ready;
    assign DATA_READY_O    = data_ready;
    assign WRITE_O         = write_reg;
    assign WRITE_COMMAND_O = write_cmd_reg;
    assign DATA_SEND_O     = data_send_reg;
    assign COMMAND_O       = command_reg;
    assign BUSY_O          = (state_reg != IDLE);
    assign FRAME_ABORT_O   = abort_reg;

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler: command/data arbitration, frame atomicity,
// starvation limit, watchdog abort, backpressure hold and asynchronous reset.
module tb_tx_scheduler;

    logic       CLK_I = 1'b0;
    logic       RST_NI = 1'b0;
    logic       CMD_VALID_I = 1'b0;
    logic [7:0] CMD_I = 8'h00;
    logic       CMD_READY_O;
    logic       DATA_VALID_I = 1'b0;
    logic [7:0] DATA_I = 8'h00;
    logic       DATA_LAST_I = 1'b0;
    logic       DATA_READY_O;
    logic       TX_READY_I = 1'b1;
    logic       WRITE_O;
    logic       WRITE_COMMAND_O;
    logic [7:0] DATA_SEND_O;
    logic [7:0] COMMAND_O;
    logic       BUSY_O;
    logic       FRAME_ABORT_O;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] wlog[$];
    bit both_high = 1'b0;

    tx_scheduler #(
        .CMD_MAX_CONSEC(4),
        .FRAME_TIMEOUT (255)
    ) dut (
        .CLK_I          (CLK_I),
        .RST_NI         (RST_NI),
        .CMD_VALID_I    (CMD_VALID_I),
        .CMD_I          (CMD_I),
        .CMD_READY_O    (CMD_READY_O),
        .DATA_VALID_I   (DATA_VALID_I),
        .DATA_I         (DATA_I),
        .DATA_LAST_I    (DATA_LAST_I),
        .DATA_READY_O   (DATA_READY_O),
        .TX_READY_I     (TX_READY_I),
        .WRITE_O        (WRITE_O),
        .WRITE_COMMAND_O(WRITE_COMMAND_O),
        .DATA_SEND_O    (DATA_SEND_O),
        .COMMAND_O      (COMMAND_O),
        .BUSY_O         (BUSY_O),
        .FRAME_ABORT_O  (FRAME_ABORT_O)
    );

    always #5 CLK_I = ~CLK_I;

    // Write log: bit 8 set for a command write, clear for a data write.
    always @(negedge CLK_I) begin
        if (WRITE_O && WRITE_COMMAND_O) both_high = 1'b1;
        if (WRITE_O) begin
            wlog.push_back({1'b0, DATA_SEND_O});
            $display("[%0t] data write %02h", $time, DATA_SEND_O);
        end
        if (WRITE_COMMAND_O) begin
            wlog.push_back({1'b1, COMMAND_O});
            $display("[%0t] cmd  write %02h", $time, COMMAND_O);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_I);
        #2;
    endtask

    initial begin
        logic [8:0] e2[4];
        logic [8:0] e3[10];
        bit seen_abort;
        bit seen_ready;
        bit seen_idle;

        e2 = '{9'h001, 9'h0B1, 9'h003, 9'h110};
        e3 = '{9'h1C5, 9'h1C5, 9'h1C5, 9'h1C5, 9'h0D7,
               9'h1C5, 9'h1C5, 9'h1C5, 9'h1C5, 9'h0D7};

        // Reset state, with a request and TX_READY present.
        CMD_VALID_I = 1'b1;
        DATA_VALID_I = 1'b1;
        #12;
        chk("rst_cmd_ready", CMD_READY_O, 0);
        chk("rst_data_ready", DATA_READY_O, 0);
        chk("rst_write", WRITE_O, 0);
        chk("rst_write_cmd", WRITE_COMMAND_O, 0);
        chk("rst_busy", BUSY_O, 0);
        chk("rst_outs", {DATA_SEND_O, COMMAND_O, 7'd0, FRAME_ABORT_O}, 0);
        CMD_VALID_I = 1'b0;
        DATA_VALID_I = 1'b0;
        tick();
        RST_NI = 1'b1;
        tick();

        // Single command.
        CMD_VALID_I = 1'b1;
        CMD_I = 8'h5A;
        #1;
        chk("t1_cmd_ready", CMD_READY_O, 1);
        chk("t1_data_ready", DATA_READY_O, 0);
        tick();
        CMD_VALID_I = 1'b0;
        chk("t1_wcmd", WRITE_COMMAND_O, 1);
        chk("t1_command", COMMAND_O, 8'h5A);
        chk("t1_write", WRITE_O, 0);
        chk("t1_busy", BUSY_O, 1);
        chk("t1_ready_issue", {CMD_READY_O, DATA_READY_O}, 0);
        tick();
        chk("t1_wcmd_gap", WRITE_COMMAND_O, 0);
        chk("t1_command_hold", COMMAND_O, 8'h5A);
        tick();
        chk("t1_idle", BUSY_O, 0);

        // Three-byte frame with a command arriving after the first byte.
        wlog.delete();
        DATA_VALID_I = 1'b1;
        DATA_I = 8'h01;
        DATA_LAST_I = 1'b0;
        #1;
        chk("t2_data_ready", DATA_READY_O, 1);
        tick();
        CMD_VALID_I = 1'b1;
        CMD_I = 8'h10;
        DATA_I = 8'hB1;
        chk("t2_write0", WRITE_O, 1);
        chk("t2_send0", DATA_SEND_O, 8'h01);
        tick();
        tick();
        chk("t2_frame_cmd_ready", CMD_READY_O, 0);
        chk("t2_frame_data_ready", DATA_READY_O, 1);
        tick();
        DATA_I = 8'h03;
        DATA_LAST_I = 1'b1;
        tick();
        tick();
        tick();
        DATA_VALID_I = 1'b0;
        DATA_LAST_I = 1'b0;
        chk("t2_send2", DATA_SEND_O, 8'h03);
        tick();
        chk("t2_gap_cmd_ready", CMD_READY_O, 0);
        tick();
        chk("t2_idle_cmd_ready", CMD_READY_O, 1);
        tick();
        CMD_VALID_I = 1'b0;
        tick();
        tick();
        chk("t2_log_len", wlog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_log%0d", i), (i < wlog.size()) ? wlog[i] : 9'h1FF, e2[i]);
        end

        // Both channels continuously valid: starvation limit forces data after 4 commands.
        wlog.delete();
        CMD_VALID_I = 1'b1;
        CMD_I = 8'hC5;
        DATA_VALID_I = 1'b1;
        DATA_I = 8'hD7;
        DATA_LAST_I = 1'b1;
        #1;
        chk("t3_first_cmd_ready", CMD_READY_O, 1);
        chk("t3_first_data_ready", DATA_READY_O, 0);
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 12) begin
                chk("t3_limit_cmd_ready", CMD_READY_O, 0);
                chk("t3_limit_data_ready", DATA_READY_O, 1);
            end
        end
        CMD_VALID_I = 1'b0;
        DATA_VALID_I = 1'b0;
        DATA_LAST_I = 1'b0;
        tick();
        tick();
        tick();
        chk("t3_log_len", wlog.size(), 10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t3_log%0d", i), (i < wlog.size()) ? wlog[i] : 9'h1FF, e3[i]);
        end

        // Watchdog: frame opened then starved of data with the link ready.
        DATA_VALID_I = 1'b1;
        DATA_I = 8'h01;
        tick();
        DATA_VALID_I = 1'b0;
        CMD_VALID_I = 1'b1;
        CMD_I = 8'hA5;
        seen_abort = 1'b0;
        seen_idle = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (FRAME_ABORT_O) seen_abort = 1'b1;
            if (!BUSY_O) seen_idle = 1'b1;
        end
        chk("t4_no_early_abort", seen_abort, 0);
        chk("t4_no_early_idle", seen_idle, 0);
        tick();
        chk("t4_abort", FRAME_ABORT_O, 1);
        chk("t4_busy", BUSY_O, 0);
        chk("t4_cmd_ready", CMD_READY_O, 1);
        tick();
        CMD_VALID_I = 1'b0;
        chk("t4_abort_pulse", FRAME_ABORT_O, 0);
        chk("t4_wcmd", WRITE_COMMAND_O, 1);
        chk("t4_command", COMMAND_O, 8'hA5);
        tick();
        tick();

        // Backpressure mid-frame must never abort and must hold readies low.
        DATA_VALID_I = 1'b1;
        DATA_I = 8'h22;
        tick();
        DATA_VALID_I = 1'b0;
        tick();
        tick();
        TX_READY_I = 1'b0;
        CMD_VALID_I = 1'b1;
        CMD_I = 8'h44;
        seen_abort = 1'b0;
        seen_ready = 1'b0;
        seen_idle = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            DATA_VALID_I = (i >= 500);
            tick();
            if (FRAME_ABORT_O) seen_abort = 1'b1;
            if (CMD_READY_O || DATA_READY_O) seen_ready = 1'b1;
            if (!BUSY_O) seen_idle = 1'b1;
        end
        chk("t5_no_abort", seen_abort, 0);
        chk("t5_no_ready", seen_ready, 0);
        chk("t5_stay_busy", seen_idle, 0);
        TX_READY_I = 1'b1;
        DATA_VALID_I = 1'b1;
        DATA_I = 8'h33;
        DATA_LAST_I = 1'b1;
        #1;
        chk("t5_resume_ready", DATA_READY_O, 1);
        chk("t5_resume_cmd_blocked", CMD_READY_O, 0);
        tick();
        DATA_VALID_I = 1'b0;
        DATA_LAST_I = 1'b0;
        chk("t5_send", DATA_SEND_O, 8'h33);
        tick();
        tick();
        chk("t5_cmd_after", CMD_READY_O, 1);
        tick();
        CMD_VALID_I = 1'b0;
        chk("t5_command", COMMAND_O, 8'h44);
        tick();
        tick();

        // Asynchronous reset while a command write is being issued.
        CMD_VALID_I = 1'b1;
        CMD_I = 8'h77;
        tick();
        CMD_VALID_I = 1'b0;
        wlog.delete();
        #1;
        RST_NI = 1'b0;
        #1;
        chk("t6_wcmd", WRITE_COMMAND_O, 0);
        chk("t6_busy", BUSY_O, 0);
        chk("t6_outs", {DATA_SEND_O, COMMAND_O, WRITE_O, CMD_READY_O, DATA_READY_O, FRAME_ABORT_O}, 0);
        tick();
        RST_NI = 1'b1;
        tick();
        chk("t6_after_wcmd", WRITE_COMMAND_O, 0);
        chk("t6_after_busy", BUSY_O, 0);
        tick();
        chk("t6_log_empty", wlog.size(), 0);
        chk("never_both_writes", both_high, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
